// File: rtl/imem_loader_if.sv
// imem_loader_if: load-stream handshake plus instruction-store write port and status flags
interface imem_loader_if #(
  parameter int d_width     = 8,
  parameter int i_adr_width = 10,
  parameter int w           = 46
);
  logic [d_width-1:0]     rx_data;
  logic                   rx_valid;
  logic                   rx_ready;
  logic [i_adr_width-1:0] imem_write_adr;
  logic                   imem_write;
  logic [w-1:0]           imem_in;
  logic                   busy;
  logic                   run;
  logic                   error;
  modport master (
    output rx_data, rx_valid,
    input  rx_ready, imem_write_adr, imem_write, imem_in, busy, run, error
  );
  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, imem_write_adr, imem_write, imem_in, busy, run, error
  );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: byte-stream command parser that assembles instruction words and writes them to the instruction store
module imem_loader #(
  parameter int d_width       = 8,
  parameter int i_adr_width   = 10,
  parameter int i_width       = 23,
  parameter int i_buffer_size = 2
) (
  input  logic clk,
  input  logic reset,
  imem_loader_if.slave lb
);
  localparam int w  = i_buffer_size * i_width;
  localparam int nb = (w + d_width - 1) / d_width;
  localparam int iw = $clog2(nb);
  localparam logic [d_width-1:0] h_adr = 'hA5;
  localparam logic [d_width-1:0] h_cnt = 'h5A;
  localparam logic [d_width-1:0] h_run = 'h3C;
  typedef enum logic [2:0] {IDLE, ADR_LO, ADR_HI, COUNT, DATA, WRITE} state_t;
  state_t                     r_state, w_next;
  logic [i_adr_width-1:0]     r_adr, r_wadr;
  logic [d_width-1:0]         r_cnt;
  logic [iw-1:0]              r_idx;
  logic [(nb-1)*d_width-1:0]  r_asm;
  logic [w-1:0]               r_imem_in;
  logic                       r_run, r_err;
  logic                       w_acc, w_last;
  logic [w-1:0]               w_word;
  assign w_acc  = lb.rx_valid && lb.rx_ready;
  assign w_last = r_idx == iw'(nb - 1);
  assign w_word = w'({lb.rx_data, r_asm});
  assign lb.imem_write_adr = r_wadr;
  assign lb.imem_in        = r_imem_in;
  assign lb.run            = r_run;
  assign lb.error          = r_err;
  // state register; reset returns the parser to IDLE and drops any partial word
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end
  // next-state and handshake/status outputs; rx_ready is held low while reset is asserted
  always_comb begin
    w_next        = r_state;
    lb.rx_ready   = reset && r_state != WRITE;
    lb.imem_write = r_state == WRITE;
    lb.busy       = r_state != IDLE;
    case (r_state)
      IDLE:    if (w_acc) w_next = lb.rx_data == h_adr ? ADR_LO : lb.rx_data == h_cnt ? COUNT : IDLE;
      ADR_LO:  if (w_acc) w_next = ADR_HI;
      ADR_HI:  if (w_acc) w_next = IDLE;
      COUNT:   if (w_acc) w_next = DATA;
      DATA:    if (w_acc && w_last) w_next = WRITE;
      WRITE:   w_next = r_cnt == '0 ? IDLE : DATA;
      default: w_next = IDLE;
    endcase
  end
  // datapath: address/count capture, little-endian word assembly, post-write address/count update
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_adr     <= '0;
      r_wadr    <= '0;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_asm     <= '0;
      r_imem_in <= '0;
      r_run     <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      if (w_acc) begin
        case (r_state)
          IDLE: begin
            r_run <= lb.rx_data == h_run;
            r_err <= r_err || !(lb.rx_data == h_adr || lb.rx_data == h_cnt || lb.rx_data == h_run);
          end
          ADR_LO: r_adr[7:0] <= lb.rx_data[7:0];
          ADR_HI: r_adr[i_adr_width-1:8] <= lb.rx_data[i_adr_width-9:0];
          COUNT: begin
            r_cnt <= lb.rx_data;
            r_idx <= '0;
          end
          DATA: begin
            r_idx <= r_idx + 1'b1;
            if (w_last) begin
              r_imem_in <= w_word;
              r_wadr    <= r_adr;
            end else begin
              r_asm[r_idx*d_width +: d_width] <= lb.rx_data;
            end
          end
          default: ;
        endcase
      end
      if (r_state == WRITE) begin
        r_adr <= r_adr + 1'b1;
        r_cnt <= r_cnt - 1'b1;
        r_idx <= '0;
      end
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: scoreboard bench for the instruction-memory loader
module tb_imem_loader;
  typedef struct packed {logic [9:0] adr; logic [45:0] dat;} wr_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int n_checks = 0;
  int n_fail = 0;
  int n_wr = 0;
  int cyc = 0;
  int last_wr = 0;
  int prev_wr = 0;
  logic [9:0] m_adr = '0;
  wr_t q[$];
  imem_loader_if lb ();
  imem_loader dut (.clk(clk), .reset(reset), .lb(lb));
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    wr_t e;
    if (reset) begin
      chk("rdy_vs_wr", lb.rx_ready, !lb.imem_write);
      if (lb.imem_write) begin
        n_wr++;
        prev_wr = last_wr;
        last_wr = cyc;
        if (q.size() == 0) chk("spurious_wr", 1, 0);
        else begin
          e = q.pop_front();
          chk("wr_adr", lb.imem_write_adr, e.adr);
          chk("wr_dat", lb.imem_in, e.dat);
        end
      end
    end
  end
  task automatic send(input logic [7:0] b, input int gap);
    int t = 0;
    if (gap > 0) begin
      lb.rx_valid = 1'b0;
      repeat ($urandom_range(0, gap)) @(negedge clk);
    end
    lb.rx_data  = b;
    lb.rx_valid = 1'b1;
    while (!lb.rx_ready) begin
      @(negedge clk);
      if (++t > 20) begin
        chk("rdy_timeout", 0, 1);
        break;
      end
    end
    @(negedge clk);
  endtask
  task automatic idle();
    lb.rx_valid = 1'b0;
  endtask
  task automatic set_adr(input logic [7:0] lo, input logic [7:0] hi);
    send(8'hA5, 0);
    send(lo, 0);
    send(hi, 0);
    m_adr = {hi[1:0], lo};
  endtask
  task automatic load_words(input int n, input logic [7:0] base, input int gap, input bit hdr);
    logic [47:0] t;
    if (hdr) send(8'h5A, gap);
    send(8'(n - 1), gap);
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < 6; i++) t[i*8 +: 8] = 8'(base + k*6 + i);
      q.push_back({m_adr, t[45:0]});
      m_adr = m_adr + 1'b1;
      for (int i = 0; i < 6; i++) send(t[i*8 +: 8], gap);
    end
    idle();
  endtask
  task automatic drain(input string tag);
    int t = 0;
    while (q.size() > 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk(tag, q.size(), 0);
    @(negedge clk);
    @(negedge clk);
  endtask
  task automatic chk_reset_vals();
    chk("rst_ready", lb.rx_ready, 0);
    chk("rst_write", lb.imem_write, 0);
    chk("rst_adr", lb.imem_write_adr, 0);
    chk("rst_in", lb.imem_in, 0);
    chk("rst_busy", lb.busy, 0);
    chk("rst_run", lb.run, 0);
    chk("rst_err", lb.error, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    int w0;
    lb.rx_data  = '0;
    lb.rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals();
    reset = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", lb.rx_ready, 1);
    chk("busy_after_rst", lb.busy, 0);
    set_adr(8'h10, 8'h02);
    load_words(1, 8'h01, 0, 1);
    drain("drain_basic");
    chk("basic_busy", lb.busy, 0);
    chk("hold_adr", lb.imem_write_adr, 10'h210);
    chk("hold_in", lb.imem_in, 46'h060504030201);
    chk("basic_count", n_wr, 1);
    set_adr(8'hFF, 8'h03);
    load_words(2, 8'hC0, 0, 1);
    drain("drain_wrap");
    chk("wrap_spacing", last_wr - prev_wr, 7);
    chk("wrap_count", n_wr, 3);
    send(8'h3C, 0);
    idle();
    @(negedge clk);
    chk("run_set", lb.run, 1);
    chk("run_busy", lb.busy, 0);
    send(8'h5A, 0);
    chk("run_clr_5a", lb.run, 0);
    load_words(1, 8'h21, 0, 0);
    drain("drain_run");
    send(8'h77, 0);
    idle();
    @(negedge clk);
    chk("err_set", lb.error, 1);
    chk("err_idle", lb.busy, 0);
    set_adr(8'h34, 8'hFD);
    load_words(1, 8'h50, 0, 1);
    drain("drain_err");
    chk("err_sticky", lb.error, 1);
    w0 = n_wr;
    set_adr(8'h20, 8'h00);
    send(8'h5A, 0);
    send(8'h00, 0);
    send(8'hAA, 0);
    send(8'hBB, 0);
    send(8'hCC, 0);
    idle();
    reset = 1'b0;
    #1;
    chk_reset_vals();
    repeat (3) @(negedge clk);
    chk("rst_no_wr", n_wr, w0);
    chk_reset_vals();
    reset = 1'b1;
    m_adr = '0;
    @(negedge clk);
    chk("rst_rel_ready", lb.rx_ready, 1);
    load_words(1, 8'h40, 0, 1);
    drain("drain_rst");
    chk("rst_fresh_count", n_wr, w0 + 1);
    w0 = n_wr;
    set_adr(8'h00, 8'h01);
    load_words(3, 8'h80, 3, 1);
    drain("drain_gaps");
    chk("gap_count", n_wr, w0 + 3);
    chk("end_busy", lb.busy, 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter d_width, default 8, byte width of the load stream.
REQ-002 Parameter i_adr_width, default 10, instruction memory address width.
REQ-003 Parameter i_width, default 23, single instruction width.
REQ-004 Parameter i_buffer_size, default 2, instructions per memory write word; word width W = i_buffer_size*i_width = 46.
REQ-005 clk  input  1  single clock; all state changes on rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 rx_data  input  d_width  load-stream byte.
REQ-008 rx_valid  input  1  rx_data valid.
REQ-009 rx_ready  output  1  loader accepts byte; transfer occurs when rx_valid and rx_ready are both high on a rising edge.
REQ-010 imem_write_adr  output  i_adr_width  registered write address to the instruction store.
REQ-011 imem_write  output  1  one-cycle write strobe.
REQ-012 imem_in  output  W  registered write data word.
REQ-013 busy  output  1  high whenever FSM is not IDLE.
REQ-014 run  output  1  level; processor is released to execute.
REQ-015 error  output  1  sticky; unknown header byte received.

Function
REQ-016 FSM states SHALL be IDLE, ADR_LO, ADR_HI, COUNT, DATA, WRITE.
REQ-017 IDLE, header 0xA5 -> ADR_LO; 0x5A -> COUNT; 0x3C -> stay IDLE, set run; any other value -> stay IDLE, set error.
REQ-018 Any accepted header other than 0x3C SHALL clear run in the same edge.
REQ-019 ADR_LO: byte loads address bits 7:0 -> ADR_HI; ADR_HI: byte bits 1:0 load address bits 9:8, upper bits ignored -> IDLE.
REQ-020 COUNT: byte loads word counter (N-1, so 1..256 words) -> DATA with byte index 0.
REQ-021 DATA: each accepted byte written little-endian into assembly register slot [index]; 6 bytes per word; bits 47:46 of the 6th byte discarded.
REQ-022 After 6th byte accepted -> WRITE; imem_in updated from assembly register on that edge.
REQ-023 WRITE lasts exactly one cycle: imem_write=1, rx_ready=0, imem_write_adr = current address.
REQ-024 On leaving WRITE, address increments by 1 modulo 2^i_adr_width (1023 -> 0); word counter decrements.
REQ-025 Leaving WRITE: counter was 0 -> IDLE, else -> DATA with byte index 0.
REQ-026 rx_ready SHALL be 1 in IDLE, ADR_LO, ADR_HI, COUNT, DATA; 0 in WRITE.
REQ-027 Bytes with rx_valid=0 SHALL not advance state; arbitrary idle gaps between bytes are legal.
REQ-028 imem_in and imem_write_adr SHALL hold their values outside WRITE.
REQ-029 Throughput: one word per 7 cycles when rx_valid is held high.
REQ-030 error cleared only by reset; error does not block further commands.
REQ-031 Setting address during run does not clear run only if header is 0x3C; 0xA5 clears run per REQ-018.

Reset
REQ-032 While reset=0: state IDLE, rx_ready=0, imem_write=0, imem_write_adr=0, imem_in=0, busy=0, run=0, error=0, counters 0.
REQ-033 rx_ready SHALL rise the first cycle after reset deasserts.
REQ-034 Reset mid-load abandons the partial word; no imem_write is issued for it.

Verification
REQ-035 Bytes A5,10,02 then 5A,00, bytes 01..06 -> one imem_write pulse, adr=0x210, imem_in=0x060504030201 (bit 46 of byte 06 masked), busy back low.
REQ-036 A5,FF,03, 5A,01, 12 data bytes -> writes at 0x3FF then 0x000 (wrap), two strobes 7 cycles apart with continuous valid.
REQ-037 Send 3C -> run=1, busy=0; then 5A,00 + 6 bytes -> run=0 on 5A acceptance, write at address following prior pointer.
REQ-038 Header 77 -> error=1 sticky, state IDLE; subsequent A5 sequence still loads address correctly.
REQ-039 Assert reset after 3 of 6 data bytes -> no imem_write, all outputs at REQ-032 values; after release, fresh load writes address 0.
REQ-040 Random rx_valid gaps during 5A,02 + 18 bytes -> exactly 3 writes, data identical to gap-free run, rx_ready low only in WRITE cycles.
